// File: rtl/vc_reset_pkg.sv
// rtl/vc_reset_pkg.sv - shared state encoding, defaults and index-width helper for vc_reset_seq
package vc_reset_pkg;

    typedef enum logic [2:0] {
        HOLD    = 3'd0,
        INV_I   = 3'd1,
        INV_D   = 3'd2,
        RELEASE = 3'd3,
        RUN     = 3'd4
    } vc_rst_state_e;

    localparam int DEF_STRETCH     = 4;
    localparam int DEF_GAP         = 2;
    localparam int DEF_WDOG_CYCLES = 1024;

    function automatic int idx_width(input int i_lines, input int d_lines);
        int w_i;
        int w_d;
        w_i = $clog2(i_lines);
        w_d = $clog2(d_lines);
        return (w_i > w_d) ? w_i : w_d;
    endfunction

endpackage

// File: rtl/vc_rst_sync.sv
// rtl/vc_rst_sync.sv - two-flop synchroniser for the pad reset, output inverted to active-high
module vc_rst_sync (
    input  logic clk,
    input  logic i_rst_n,
    output logic o_rst
);

    logic [1:0] r_sync;

    // No reset on these flops: they are what brings the pad reset into the clock domain.
    always_ff @(posedge clk) begin
        r_sync <= {r_sync[0], i_rst_n};
    end

    assign o_rst = ~r_sync[1];

endmodule

// File: rtl/vc_reset_seq.sv
// rtl/vc_reset_seq.sv - staged reset sequencer: cache invalidate sweep then ordered domain release
// Optional watchdog in RUN enabled by defining VC_RESET_SEQ_WDOG_EN.
module vc_reset_seq
    import vc_reset_pkg::*;
#(
    parameter  int NDOM        = 3,
    parameter  int STRETCH     = DEF_STRETCH,
    parameter  int GAP         = DEF_GAP,
    parameter  int I_NLINES    = 8,
    parameter  int D_NLINES    = 8,
    parameter  int WDOG_CYCLES = DEF_WDOG_CYCLES,
    localparam int IDX_W       = idx_width(I_NLINES, D_NLINES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ext_rst_n,
    input  logic             ena,
    output logic [NDOM-1:0]  dom_reset,
    output logic             inv_valid,
    output logic             inv_icache,
    output logic [IDX_W-1:0] inv_index,
    input  logic             inv_ready,
    output logic             ready,
    output logic [2:0]       state_o,
    input  logic             alive,
    output logic             wdog_fired
);

    localparam int I_W      = $clog2(I_NLINES);
    localparam int D_W      = $clog2(D_NLINES);
    localparam int HOLD_W   = $clog2(STRETCH + 1);
    localparam int REL_LAST = (NDOM - 1) * GAP + 1;
    localparam int REL_W    = $clog2(REL_LAST + 1);

    vc_rst_state_e    r_state;
    logic [NDOM-1:0]  r_dom_reset;
    logic             r_inv_valid;
    logic             r_inv_icache;
    logic [IDX_W-1:0] r_inv_index;
    logic             r_ready;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [REL_W-1:0] r_rel_cnt;

    logic             w_rst_sync;
    logic             w_src;
    logic             w_hs;
    logic             w_wdog_trip;
    logic [REL_W-1:0] w_rel_next;
    logic [NDOM-1:0]  w_rel_clr;

    vc_rst_sync u_rst_sync (
        .clk     (clk),
        .i_rst_n (ext_rst_n),
        .o_rst   (w_rst_sync)
    );

    assign w_src      = reset | w_rst_sync | ~ena;
    assign w_hs       = r_inv_valid & inv_ready;
    assign w_rel_next = r_rel_cnt + 1'b1;

    // Domain i drops when the release counter reaches i*GAP; domain 0 already dropped on entry.
    always_comb begin
        w_rel_clr = '0;
        for (int i = 0; i < NDOM; i++) begin
            w_rel_clr[i] = (w_rel_next == REL_W'(i * GAP));
        end
    end

`ifdef VC_RESET_SEQ_WDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
    logic [WDOG_W-1:0] r_wdog_cnt;
    logic              r_wdog_fired;

    assign w_wdog_trip = (r_state == RUN) & ~alive & (r_wdog_cnt == WDOG_W'(WDOG_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (w_src || w_wdog_trip || alive || r_state != RUN) begin
            r_wdog_cnt <= '0;
        end else begin
            r_wdog_cnt <= r_wdog_cnt + 1'b1;
        end
        if (w_src) begin
            r_wdog_fired <= 1'b0;
        end else if (w_wdog_trip) begin
            r_wdog_fired <= 1'b1;
        end
    end

    assign wdog_fired = r_wdog_fired;
`else
    logic w_unused_wdog;
    assign w_unused_wdog = alive ^ (WDOG_CYCLES == 0);
    assign w_wdog_trip   = 1'b0;
    assign wdog_fired    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (w_src || w_wdog_trip) begin
            r_state      <= HOLD;
            r_dom_reset  <= '1;
            r_inv_valid  <= 1'b0;
            r_inv_icache <= 1'b1;
            r_inv_index  <= '0;
            r_ready      <= 1'b0;
            r_hold_cnt   <= '0;
            r_rel_cnt    <= '0;
        end else begin
            case (r_state)
                HOLD: begin
                    if (r_hold_cnt == HOLD_W'(STRETCH - 1)) begin
                        r_state      <= INV_I;
                        r_inv_valid  <= 1'b1;
                        r_inv_icache <= 1'b1;
                        r_inv_index  <= '0;
                        r_hold_cnt   <= '0;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                INV_I: begin
                    if (w_hs) begin
                        if (r_inv_index[I_W-1:0] == I_W'(I_NLINES - 1)) begin
                            r_state      <= INV_D;
                            r_inv_icache <= 1'b0;
                            r_inv_index  <= '0;
                        end else begin
                            r_inv_index <= r_inv_index + 1'b1;
                        end
                    end
                end
                INV_D: begin
                    if (w_hs) begin
                        if (r_inv_index[D_W-1:0] == D_W'(D_NLINES - 1)) begin
                            r_state        <= RELEASE;
                            r_inv_valid    <= 1'b0;
                            r_inv_index    <= '0;
                            r_dom_reset[0] <= 1'b0;
                            r_rel_cnt      <= '0;
                        end else begin
                            r_inv_index <= r_inv_index + 1'b1;
                        end
                    end
                end
                RELEASE: begin
                    r_rel_cnt   <= w_rel_next;
                    r_dom_reset <= r_dom_reset & ~w_rel_clr;
                    if (w_rel_next == REL_W'(REL_LAST)) begin
                        r_state     <= RUN;
                        r_ready     <= 1'b1;
                        r_dom_reset <= '0;
                    end
                end
                RUN: begin
                    r_dom_reset <= '0;
                    r_ready     <= 1'b1;
                end
                default: r_state <= HOLD;
            endcase
        end
    end

    assign dom_reset  = r_dom_reset;
    assign inv_valid  = r_inv_valid;
    assign inv_icache = r_inv_icache;
    assign inv_index  = r_inv_index;
    assign ready      = r_ready;
    assign state_o    = r_state;

endmodule

// File: tb/tb_vc_reset_seq.sv
// tb/tb_vc_reset_seq.sv - directed bench for vc_reset_seq (default and small-config instances)
module tb_vc_reset_seq;

    logic       clk = 1'b0;
    logic       reset, ext_rst_n, ena, inv_ready, alive;
    logic [2:0] dom_reset;
    logic       inv_valid, inv_icache, ready, wdog_fired;
    logic [2:0] inv_index;
    logic [2:0] state_o;

    logic       reset2, inv_ready2;
    logic [0:0] dom2;
    logic       inv_valid2, icache2, ready2, wdog2;
    logic [3:0] index2;
    logic [2:0] state2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    vc_reset_seq #(.WDOG_CYCLES(8)) u_dut (
        .clk(clk), .reset(reset), .ext_rst_n(ext_rst_n), .ena(ena),
        .dom_reset(dom_reset), .inv_valid(inv_valid), .inv_icache(inv_icache),
        .inv_index(inv_index), .inv_ready(inv_ready), .ready(ready),
        .state_o(state_o), .alive(alive), .wdog_fired(wdog_fired)
    );

    vc_reset_seq #(.NDOM(1), .I_NLINES(4), .D_NLINES(16)) u_dut2 (
        .clk(clk), .reset(reset2), .ext_rst_n(ext_rst_n), .ena(1'b1),
        .dom_reset(dom2), .inv_valid(inv_valid2), .inv_icache(icache2),
        .inv_index(index2), .inv_ready(inv_ready2), .ready(ready2),
        .state_o(state2), .alive(alive), .wdog_fired(wdog2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic to_inv_i();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_wait", 32'(state_o), 32'd0);
        end
        tick();
        chk("enter_inv_i", 32'(state_o), 32'd1);
        chk("enter_inv_i_idx", 32'(inv_index), 32'd0);
    endtask

    task automatic run_to_run();
        for (int i = 0; i < 16; i++) tick();
        chk("rel_entry_state", 32'(state_o), 32'd3);
        chk("rel_entry_dom", 32'(dom_reset), 32'b110);
        for (int i = 0; i < 4; i++) tick();
        chk("rel_all_dom", 32'(dom_reset), 32'b000);
        tick();
        chk("run_state", 32'(state_o), 32'd4);
        chk("run_ready", 32'(ready), 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; ext_rst_n = 1'b1; ena = 1'b1; inv_ready = 1'b1; alive = 1'b0;
        reset2 = 1'b1; inv_ready2 = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("rst_dom", 32'(dom_reset), 32'b111);
        chk("rst_valid", 32'(inv_valid), 32'd0);
        chk("rst_icache", 32'(inv_icache), 32'd1);
        chk("rst_index", 32'(inv_index), 32'd0);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_wdog", 32'(wdog_fired), 32'd0);

        // Full default sequence with dom_reset stepping checked cycle by cycle.
        reset = 1'b0;
        to_inv_i();
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("i_idx%0d", i), 32'(inv_index), 32'(i));
            chk("i_sel", 32'({inv_valid, inv_icache, state_o}), 32'b11_001);
            tick();
        end
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("d_idx%0d", i), 32'(inv_index), 32'(i));
            chk("d_sel", 32'({inv_valid, inv_icache, state_o}), 32'b10_010);
            tick();
        end
        chk("rel0_dom", 32'(dom_reset), 32'b110);
        chk("rel0_valid", 32'(inv_valid), 32'd0);
        tick(); chk("rel1_dom", 32'(dom_reset), 32'b110);
        tick(); chk("rel2_dom", 32'(dom_reset), 32'b100);
        tick(); chk("rel3_dom", 32'(dom_reset), 32'b100);
        tick(); chk("rel4_dom", 32'(dom_reset), 32'b000);
        chk("rel4_ready", 32'(ready), 32'd0);
        tick();
        chk("run_ready", 32'(ready), 32'd1);
        chk("run_state", 32'(state_o), 32'd4);

        // ena low in RUN, then a too-short ena high glitch.
        ena = 1'b0;
        tick();
        chk("ena_ready", 32'(ready), 32'd0);
        chk("ena_dom", 32'(dom_reset), 32'b111);
        chk("ena_state", 32'(state_o), 32'd0);
        ena = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("glitch_hold", 32'(state_o), 32'd0);
        end
        ena = 1'b0;
        tick();
        chk("glitch_end", 32'(state_o), 32'd0);
        ena = 1'b1;
        to_inv_i();

        // Back-pressure at I index 5.
        for (int i = 0; i < 5; i++) tick();
        inv_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_idx", 32'(inv_index), 32'd5);
            chk("stall_sel", 32'({inv_valid, inv_icache}), 32'b11);
        end
        inv_ready = 1'b1;
        tick();
        chk("stall_adv", 32'(inv_index), 32'd6);
        tick(); tick();
        chk("stall_to_d", 32'({state_o, inv_index}), 32'({3'd2, 3'd0}));

        // Pad reset pulse during D index 3.
        tick(); tick(); tick();
        chk("pad_d3", 32'(inv_index), 32'd3);
        ext_rst_n = 1'b0;
        tick();
        chk("pad_k1", 32'({state_o, inv_index}), 32'({3'd2, 3'd4}));
        ext_rst_n = 1'b1;
        tick();
        tick();
        chk("pad_hold", 32'(state_o), 32'd0);
        chk("pad_valid", 32'(inv_valid), 32'd0);
        chk("pad_dom", 32'(dom_reset), 32'b111);
        to_inv_i();
        run_to_run();

`ifdef VC_RESET_SEQ_WDOG_EN
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("wdog_wait", 32'({state_o, wdog_fired}), 32'({3'd4, 1'b0}));
        end
        tick();
        chk("wdog_fire", 32'({state_o, wdog_fired}), 32'({3'd0, 1'b1}));
        chk("wdog_dom", 32'(dom_reset), 32'b111);
        chk("wdog_ready", 32'(ready), 32'd0);
        to_inv_i();
        run_to_run();
        chk("wdog_sticky", 32'(wdog_fired), 32'd1);
        for (int i = 0; i < 40; i++) begin
            alive = ((i % 5) == 4);
            tick();
            chk("alive_run", 32'(state_o), 32'd4);
        end
        alive = 1'b0;
        reset = 1'b1;
        tick();
        chk("wdog_clear", 32'(wdog_fired), 32'd0);
        reset = 1'b0;
`else
        for (int i = 0; i < 20; i++) tick();
        chk("nowdog_state", 32'(state_o), 32'd4);
        chk("nowdog_fired", 32'(wdog_fired), 32'd0);
`endif

        // Small config: 4 I lines, 16 D lines, a single domain.
        reset2 = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("c2_hold", 32'({state2, dom2}), 32'({3'd0, 1'b1}));
        tick();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("c2_i%0d", i), 32'({state2, icache2, index2}), 32'({3'd1, 1'b1, 4'(i)}));
            tick();
        end
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("c2_d%0d", i), 32'({state2, icache2, index2}), 32'({3'd2, 1'b0, 4'(i)}));
            tick();
        end
        chk("c2_rel", 32'({state2, dom2, ready2, inv_valid2}), 32'({3'd3, 1'b0, 1'b0, 1'b0}));
        tick();
        chk("c2_run", 32'({state2, ready2}), 32'({3'd4, 1'b1}));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vc_reset_seq.md
Name: vc_reset_seq

Overview:
- Parametrised reset/enable sequencer for the vc CPU top level.
- Replaces the single registered reset with a multi-domain, staged reset release.
- Merges the pad reset, the tile enable and the synchronous system reset into one reset condition.
- Walks an invalidate sweep over the I-cache and D-cache tag arrays, then releases NDOM reset domains in order (MMU, caches, core). Sits between the TinyTapeout wrapper and the vc core.

Parameters:
- NDOM, 3: number of reset domains, released in ascending index order.
- STRETCH, 4: consecutive clear cycles required in HOLD before sequencing starts (>=1).
- GAP, 2: cycles between successive domain releases (>=1).
- I_NLINES, 8: I-cache lines to invalidate (power of 2, >=2).
- D_NLINES, 8: D-cache lines to invalidate (power of 2, >=2).
- WDOG_CYCLES, 1024: watchdog timeout; used only with the optional feature.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high system reset.
- ext_rst_n  in  1  raw pad reset, active low, asynchronous to clk.
- ena  in  1  tile enable; low is treated as reset.
- dom_reset  out  NDOM  per-domain active-high reset.
- inv_valid  out  1  invalidate request.
- inv_icache  out  1  target of the request: 1 = I-cache, 0 = D-cache.
- inv_index  out  max($clog2(I_NLINES),$clog2(D_NLINES))  line index.
- inv_ready  in  1  cache accepts the invalidate.
- ready  out  1  all domains released.
- state_o  out  3  current FSM state, for debug.
- alive  in  1  core heartbeat pulse.
- wdog_fired  out  1  sticky watchdog flag.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- ext_rst_n passes through a 2-flop synchroniser: 2 cycles latency, then inverted.
- src = reset | rst_sync | ~ena.
- All outputs are registered.
- Reset/HOLD values: dom_reset = all 1s, inv_valid = 0, inv_icache = 1, inv_index = 0, ready = 0, state_o = HOLD, wdog_fired = 0.
- Priority: src asserted in any state sends the FSM to HOLD on the next edge. Outputs return to HOLD values on that edge, including mid-sweep, mid-release and in RUN. An outstanding inv_valid is dropped without handshake.
- HOLD (0):
  - hold counter clears whenever src = 1 and increments on each src = 0 cycle.
  - At count STRETCH-1 with src = 0: go to INV_I with index 0, inv_icache = 1, inv_valid = 1.
- INV_I (1):
  - inv_valid stays high; inv_index and inv_icache are stable while inv_valid & !inv_ready.
  - On each handshake, index increments.
  - Handshake at index I_NLINES-1: go to INV_D with index 0, inv_icache = 0. No bubble.
- INV_D (2):
  - Same rules as INV_I.
  - Handshake at D_NLINES-1: go to RELEASE, inv_valid = 0, index = 0.
- RELEASE (3):
  - dom_reset[0] falls on entry.
  - dom_reset[i] falls i*GAP cycles after entry.
  - The cycle after dom_reset[NDOM-1] falls: go to RUN, ready = 1.
  - A domain, once released, stays released until src or the watchdog fires.
- RUN (4): dom_reset = 0, ready = 1. Held until src.
- With inv_ready tied high and defaults, the sweep takes 16 cycles.
- Index width: the narrower cache's terminal index compares only its own $clog2 bits; the upper bits are 0.

Optional Feature:
- Macro: VC_RESET_SEQ_WDOG_EN.
- With the macro:
  - In RUN, a wdog counter increments each cycle and clears on alive = 1.
  - When the counter reaches WDOG_CYCLES-1 without alive: wdog_fired sets (sticky, cleared only by src) and the FSM goes to HOLD, re-running the full sequence.
  - The counter is cleared outside RUN.
- Without the macro:
  - Ports remain; alive is ignored, wdog_fired is tied 0.
  - No counter is synthesised.

Decomposition:
- Package vc_reset_pkg holds:
  - the state enum: HOLD=0, INV_I=1, INV_D=2, RELEASE=3, RUN=4;
  - default constants for STRETCH, GAP and WDOG_CYCLES;
  - the index-width function.
- Sub-module vc_rst_sync: 2-flop synchroniser with inverted output, used for ext_rst_n.

Test Plan:
- Defaults, inv_ready = 1, reset pulsed then low: 4 HOLD cycles; 8 I-invalidates with indices 0-7; 8 D-invalidates with indices 0-7; dom_reset steps 111 -> 110 -> (2 cycles) 100 -> (2 cycles) 000; ready rises 1 cycle later.
- inv_ready low for 3 cycles at I index 5: inv_index held at 5, inv_icache = 1, inv_valid = 1 throughout; index advances to 6 the cycle after ready.
- ext_rst_n low for 1 cycle during INV_D index 3: 2 cycles later the FSM enters HOLD, inv_valid = 0, dom_reset = 111; the sequence restarts from I index 0.
- ena = 0 in RUN: next edge gives ready = 0, dom_reset = 111. ena glitching high for 3 cycles then low: the FSM never leaves HOLD (STRETCH = 4 not met).
- I_NLINES = 4, D_NLINES = 16, NDOM = 1: I indices 0-3, D indices 0-15; a single dom_reset falls on RELEASE entry; ready 1 cycle later.
- With VC_RESET_SEQ_WDOG_EN and WDOG_CYCLES = 8:
  - no alive for 8 cycles in RUN: wdog_fired = 1, FSM in HOLD, sequence reruns, wdog_fired still 1;
  - alive every 5 cycles: never fires.
